// File: rtl/branch_cond_resolve.sv
// Branch condition resolve stage: NZCV flag register, in-flight flag-writer tracking,
// stalling branch evaluation. Optional forwarding of writeback flags: BRANCH_COND_FLAG_FWD_EN.
module branch_cond_resolve #(
    parameter int unsigned PEND_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] alu_flags,
    input  logic       flag_wr_valid,
    input  logic       flag_issue,
    output logic       flag_issue_ready,
    input  logic       flush,
    input  logic       br_valid,
    input  logic [3:0] br_cond,
    output logic       br_ready,
    output logic       br_resp_valid,
    output logic       br_taken,
    output logic [3:0] cond
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [PEND_W-1:0] pending;
    logic              resp_q;
    logic              issue_acc;
    logic              wr_dec;
    logic              uncond;
    logic              ok;
    logic              taken_c;
    logic [3:0]        eval_flags;

    // Evaluate a 4-bit condition code against NZCV flags.
    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        r  = 1'b0;
        case (c)
            4'd0:  r = z;
            4'd1:  r = !z;
            4'd2:  r = cy;
            4'd3:  r = !cy;
            4'd4:  r = n;
            4'd5:  r = !n;
            4'd6:  r = v;
            4'd7:  r = !v;
            4'd8:  r = cy && !z;
            4'd9:  r = !cy || z;
            4'd10: r = (n == v);
            4'd11: r = (n != v);
            4'd12: r = !z && (n == v);
            4'd13: r = z || (n != v);
            4'd14: r = 1'b1;
            4'd15: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign flag_issue_ready = (pending != PEND_MAX) || flag_wr_valid;
    assign issue_acc        = flag_issue && flag_issue_ready;
    assign wr_dec           = flag_wr_valid && (pending != '0);
    assign uncond           = (br_cond[3:1] == 3'b111);

`ifdef BRANCH_COND_FLAG_FWD_EN
    // The last outstanding writer completing this cycle can be consumed directly.
    assign ok         = (pending == '0) || uncond || ((pending == PEND_ONE) && flag_wr_valid);
    assign eval_flags = flag_wr_valid ? alu_flags : cond;
`else
    assign ok         = (pending == '0) || uncond;
    assign eval_flags = cond;
`endif

    assign taken_c       = eval_cond(br_cond, eval_flags);
    assign br_ready      = br_valid && ok && !flush && ((state == IDLE) || (state == WAIT));
    assign br_resp_valid = resp_q && !flush;

    // Architectural flag register; written even during flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond <= 4'b0000;
        end else if (flag_wr_valid) begin
            cond <= alu_flags;
        end
    end

    // Outstanding flag-writer counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else if (issue_acc && !wr_dec) begin
            pending <= pending + PEND_ONE;
        end else if (wr_dec && !issue_acc) begin
            pending <= pending - PEND_ONE;
        end
    end

    // Branch handshake FSM with registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            resp_q   <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state)
                IDLE, WAIT: begin
                    if (br_ready) begin
                        state    <= RESP;
                        resp_q   <= 1'b1;
                        br_taken <= taken_c;
                    end else if (br_valid && !flush) begin
                        state <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_cond_resolve.sv
// Directed self-checking bench for branch_cond_resolve (both forwarding builds).
module tb_branch_cond_resolve;

    logic       clk;
    logic       rst;
    logic [3:0] alu_flags;
    logic       flag_wr_valid;
    logic       flag_issue;
    logic       flag_issue_ready;
    logic       flush;
    logic       br_valid;
    logic [3:0] br_cond;
    logic       br_ready;
    logic       br_resp_valid;
    logic       br_taken;
    logic [3:0] cond;

    int tests;
    int fails;

    branch_cond_resolve #(.PEND_W(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_flags        (alu_flags),
        .flag_wr_valid    (flag_wr_valid),
        .flag_issue       (flag_issue),
        .flag_issue_ready (flag_issue_ready),
        .flush            (flush),
        .br_valid         (br_valid),
        .br_cond          (br_cond),
        .br_ready         (br_ready),
        .br_resp_valid    (br_resp_valid),
        .br_taken         (br_taken),
        .cond             (cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_flags = 4'b0; flag_wr_valid = 1'b0; flag_issue = 1'b0;
        flush = 1'b0; br_valid = 1'b0; br_cond = 4'd0;
        #2;
        tests++; if (cond !== 4'b0000) begin fails++; $display("FAIL reset_cond got %b want 0000", cond); end
        tests++; if (br_resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", br_resp_valid); end
        tests++; if (br_taken !== 1'b0) begin fails++; $display("FAIL reset_taken got %b want 0", br_taken); end
        tests++; if (flag_issue_ready !== 1'b1) begin fails++; $display("FAIL reset_issue_ready got %b want 1", flag_issue_ready); end
        tick(); tick();
        rst = 1'b0;
        br_valid = 1'b1; br_cond = 4'd0;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL first_eq_ready got %b want 1", br_ready); end
        tick();
        br_valid = 1'b0;
        tests++; if (br_resp_valid !== 1'b1) begin fails++; $display("FAIL first_eq_resp got %b want 1", br_resp_valid); end
        tests++; if (br_taken !== 1'b0) begin fails++; $display("FAIL first_eq_taken got %b want 0", br_taken); end
        tick();
        tests++; if (br_resp_valid !== 1'b0) begin fails++; $display("FAIL resp_one_cycle got %b want 0", br_resp_valid); end
    endtask

    task automatic test_stall_writeback();
        flag_issue = 1'b1;
        #1;
        tests++; if (flag_issue_ready !== 1'b1) begin fails++; $display("FAIL stall_issue_ready got %b want 1", flag_issue_ready); end
        tick();
        flag_issue = 1'b0;
        br_valid = 1'b1; br_cond = 4'd1;
        #1;
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL stall_t0_ready got %b want 0", br_ready); end
        tick();
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL stall_t1_ready got %b want 0", br_ready); end
        tick();
        flag_wr_valid = 1'b1; alu_flags = 4'b0100;
        #1;
`ifdef BRANCH_COND_FLAG_FWD_EN
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL fwd_wb_ready got %b want 1", br_ready); end
        tick();
        flag_wr_valid = 1'b0; br_valid = 1'b0;
`else
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL nofwd_wb_ready got %b want 0", br_ready); end
        tick();
        flag_wr_valid = 1'b0;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL nofwd_after_wb_ready got %b want 1", br_ready); end
        tick();
        br_valid = 1'b0;
`endif
        tests++; if (br_resp_valid !== 1'b1) begin fails++; $display("FAIL stall_resp got %b want 1", br_resp_valid); end
        tests++; if (br_taken !== 1'b0) begin fails++; $display("FAIL stall_ne_taken got %b want 0", br_taken); end
        tests++; if (cond !== 4'b0100) begin fails++; $display("FAIL stall_cond got %b want 0100", cond); end
        tick();
    endtask

    task automatic test_pend_max();
        flag_issue = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (flag_issue_ready !== 1'b1) begin fails++; $display("FAIL max_issue%0d_ready got %b want 1", i, flag_issue_ready); end
            tick();
        end
        #1;
        tests++; if (flag_issue_ready !== 1'b0) begin fails++; $display("FAIL max_full_ready got %b want 0", flag_issue_ready); end
        flag_wr_valid = 1'b1; alu_flags = 4'b1001;
        #1;
        tests++; if (flag_issue_ready !== 1'b1) begin fails++; $display("FAIL max_issue_wb_ready got %b want 1", flag_issue_ready); end
        tick();
        flag_issue = 1'b0; flag_wr_valid = 1'b0;
        #1;
        tests++; if (flag_issue_ready !== 1'b0) begin fails++; $display("FAIL max_still3_ready got %b want 0", flag_issue_ready); end
        flag_wr_valid = 1'b1;
        tick();
        flag_wr_valid = 1'b0;
        #1;
        tests++; if (flag_issue_ready !== 1'b1) begin fails++; $display("FAIL max_pend2_ready got %b want 1", flag_issue_ready); end
        br_valid = 1'b1; br_cond = 4'd0;
        #1;
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL pend2_eq_ready got %b want 0", br_ready); end
        br_cond = 4'd14;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL pend2_al_ready got %b want 1", br_ready); end
        tick();
        br_valid = 1'b0;
        tests++; if (br_resp_valid !== 1'b1 || br_taken !== 1'b1) begin fails++; $display("FAIL pend2_al_resp got v=%b t=%b want v=1 t=1", br_resp_valid, br_taken); end
        tick();
        br_valid = 1'b1; br_cond = 4'd15;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL pend2_nv_ready got %b want 1", br_ready); end
        tick();
        br_valid = 1'b0;
        tests++; if (br_resp_valid !== 1'b1 || br_taken !== 1'b0) begin fails++; $display("FAIL pend2_nv_resp got v=%b t=%b want v=1 t=0", br_resp_valid, br_taken); end
        flag_wr_valid = 1'b1;
        tick(); tick();
        flag_wr_valid = 1'b0;
    endtask

    task automatic run_branch(input logic [3:0] c, input logic exp, input string name);
        br_valid = 1'b1; br_cond = c;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL %s_ready got %b want 1", name, br_ready); end
        tick();
        br_valid = 1'b0;
        tests++; if (br_resp_valid !== 1'b1 || br_taken !== exp) begin fails++; $display("FAIL %s_resp got v=%b t=%b want v=1 t=%b", name, br_resp_valid, br_taken, exp); end
        tick();
    endtask

    task automatic test_cond_codes();
        // flags 1001: N=1 Z=0 C=0 V=1
        run_branch(4'd10, 1'b1, "ge_1001");
        run_branch(4'd11, 1'b0, "lt_1001");
        run_branch(4'd12, 1'b1, "gt_1001");
        run_branch(4'd15, 1'b0, "nv_1001");
        run_branch(4'd0,  1'b0, "eq_1001");
        run_branch(4'd1,  1'b1, "ne_1001");
        run_branch(4'd2,  1'b0, "cs_1001");
        run_branch(4'd4,  1'b1, "mi_1001");
        run_branch(4'd6,  1'b1, "vs_1001");
        run_branch(4'd8,  1'b0, "hi_1001");
        run_branch(4'd9,  1'b1, "ls_1001");
        run_branch(4'd13, 1'b0, "le_1001");
        // flags 0110: N=0 Z=1 C=1 V=0, written with no writer outstanding
        flag_wr_valid = 1'b1; alu_flags = 4'b0110;
        tick();
        flag_wr_valid = 1'b0;
        tests++; if (cond !== 4'b0110) begin fails++; $display("FAIL stray_wb_cond got %b want 0110", cond); end
        #1;
        run_branch(4'd8,  1'b0, "hi_0110");
        run_branch(4'd10, 1'b1, "ge_0110");
        run_branch(4'd12, 1'b0, "gt_0110");
        run_branch(4'd13, 1'b1, "le_0110");
        run_branch(4'd3,  1'b0, "cc_0110");
        run_branch(4'd5,  1'b1, "pl_0110");
        run_branch(4'd7,  1'b1, "vc_0110");
        run_branch(4'd14, 1'b1, "al_0110");
    endtask

    task automatic test_back_to_back();
        br_valid = 1'b1; br_cond = 4'd0;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL b2b_c0_ready got %b want 1", br_ready); end
        tick();
        tests++; if (br_resp_valid !== 1'b1 || br_taken !== 1'b1) begin fails++; $display("FAIL b2b_c1_resp got v=%b t=%b want v=1 t=1", br_resp_valid, br_taken); end
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL b2b_c1_ready got %b want 0", br_ready); end
        br_cond = 4'd1;
        tick();
        tests++; if (br_resp_valid !== 1'b0) begin fails++; $display("FAIL b2b_c2_resp got %b want 0", br_resp_valid); end
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL b2b_c2_ready got %b want 1", br_ready); end
        tick();
        br_valid = 1'b0;
        tests++; if (br_resp_valid !== 1'b1 || br_taken !== 1'b0) begin fails++; $display("FAIL b2b_c3_resp got v=%b t=%b want v=1 t=0", br_resp_valid, br_taken); end
        tick();
    endtask

    task automatic test_flush();
        flag_issue = 1'b1;
        tick();
        flag_issue = 1'b0;
        br_valid = 1'b1; br_cond = 4'd0;
        #1;
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL flush_wait_ready got %b want 0", br_ready); end
        tick(); tick();
        flush = 1'b1;
        #1;
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL flush_cycle_ready got %b want 0", br_ready); end
        tick();
        flush = 1'b0; br_valid = 1'b0;
        tests++; if (br_resp_valid !== 1'b0) begin fails++; $display("FAIL flush_no_resp got %b want 0", br_resp_valid); end
        tick();
        tests++; if (br_resp_valid !== 1'b0) begin fails++; $display("FAIL flush_no_resp2 got %b want 0", br_resp_valid); end
        run_branch(4'd0, 1'b1, "post_flush_eq");
        // flush during an otherwise acceptable request and during RESP
        br_valid = 1'b1; br_cond = 4'd14; flush = 1'b1;
        #1;
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL flush_idle_ready got %b want 0", br_ready); end
        flush = 1'b0;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL flush_idle_after_ready got %b want 1", br_ready); end
        tick();
        br_valid = 1'b0; flush = 1'b1;
        #1;
        tests++; if (br_resp_valid !== 1'b0) begin fails++; $display("FAIL flush_resp_forced got %b want 0", br_resp_valid); end
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset_resp();
        flag_issue = 1'b1;
        tick();
        flag_issue = 1'b0;
        br_valid = 1'b1; br_cond = 4'd14;
        tick();
        br_valid = 1'b0;
        tests++; if (br_resp_valid !== 1'b1 || br_taken !== 1'b1) begin fails++; $display("FAIL rr_resp got v=%b t=%b want v=1 t=1", br_resp_valid, br_taken); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (br_resp_valid !== 1'b0) begin fails++; $display("FAIL rr_async_resp got %b want 0", br_resp_valid); end
        tests++; if (br_taken !== 1'b0) begin fails++; $display("FAIL rr_async_taken got %b want 0", br_taken); end
        tests++; if (cond !== 4'b0000) begin fails++; $display("FAIL rr_async_cond got %b want 0000", cond); end
        tick();
        rst = 1'b0;
        br_valid = 1'b1; br_cond = 4'd0;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL rr_idle_ready got %b want 1", br_ready); end
        tick();
        br_valid = 1'b0;
        tests++; if (br_resp_valid !== 1'b1 || br_taken !== 1'b0) begin fails++; $display("FAIL rr_eq_resp got v=%b t=%b want v=1 t=0", br_resp_valid, br_taken); end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_stall_writeback();
        test_pend_max();
        test_cond_codes();
        test_back_to_back();
        test_flush();
        test_reset_resp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_cond_resolve.md
Name: branch_cond_resolve

Overview:
- Condition stage directly downstream of the ALU flag capture.
- Holds the architectural NZCV flag register and tracks in-flight flag-setting instructions.
- Evaluates 4-bit branch condition codes from decode against the flags.
- Stalls branch resolution with a valid/ready handshake until all older flag writers have written back.
- Returns a registered taken/not-taken response.

Parameters:
- PEND_W, 2, width of the in-flight flag-writer counter; max outstanding = 2^PEND_W - 1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_flags  in  4  flags from writeback: [3]=N [2]=Z [1]=C [0]=V
- flag_wr_valid  in  1  a flag-setting instruction writes alu_flags this cycle
- flag_issue  in  1  a flag-setting instruction requests issue
- flag_issue_ready  out  1  issue accepted; low when the counter is at max
- flush  in  1  pipeline flush
- br_valid  in  1  branch request present; held until br_ready
- br_cond  in  4  condition code, stable while br_valid
- br_ready  out  1  branch accepted this cycle (combinational)
- br_resp_valid  out  1  one-cycle response strobe
- br_taken  out  1  result; valid with br_resp_valid
- cond  out  4  current flag register

Behaviour:
- Reset values: cond=4'b0000, pending=0, FSM=IDLE, br_resp_valid=0, br_taken=0.
- flag_issue_ready = (pending != max) or flag_wr_valid.
- Flag register: on flag_wr_valid, cond <= alu_flags. This write happens even during a flush cycle.
- Pending counter update:
  - +1 on flag_issue & flag_issue_ready.
  - -1 on flag_wr_valid while pending > 0.
  - Issue and write in the same cycle: unchanged.
  - flag_wr_valid while pending = 0: ignored for the counter, cond still written.
  - flush: pending <= 0, overriding any increment or decrement.
- Condition codes:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V.
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
  - Codes 14 and 15 never wait on pending.
- Flags ready (ok): pending == 0, or br_cond is 14/15.
- FSM states IDLE, WAIT, RESP:
  - IDLE: br_valid & ok & !flush → br_ready=1, latch taken from cond, go to RESP. br_valid & !ok → WAIT.
  - WAIT: br_ready=0 until ok. Then accept as in IDLE and go to RESP. flush → IDLE, no response; the branch is dropped and the requester must deassert br_valid.
  - RESP: br_resp_valid=1 for exactly one cycle with br_taken. Return to IDLE. A new request can be accepted the cycle after RESP, so throughput is one branch per 2 cycles.
  - Flush in RESP: br_resp_valid forced 0 that cycle.
- Latency: branch accepted at cycle t (br_ready=1), response at t+1.
- br_ready is never asserted while flush=1.
- Async reset mid-operation returns every output to its reset value immediately. Pending writers are forgotten.

Optional Feature:
- Macro BRANCH_COND_FLAG_FWD_EN.
- Defined:
  - ok also holds when pending == 1 and flag_wr_valid is high.
  - The condition is evaluated on alu_flags (forwarded) instead of cond.
  - Saves one stall cycle.
- Undefined: evaluation always uses the registered cond, and only after pending reaches 0.

Test Plan:
- Reset with rst=1 → cond=0000, br_resp_valid=0, flag_issue_ready=1. Then br_cond=0 (EQ) with pending 0 → br_ready same cycle, next cycle br_resp_valid=1, br_taken=0.
- Issue 1 writer; branch cond=1 (NE) arrives → br_ready low. Writeback alu_flags=0100 two cycles later:
  - without FWD: accept the cycle after writeback, br_taken=0;
  - with FWD: accept on the writeback cycle using the forwarded flags, br_taken=0.
- PEND_W=2: issue 3 writers → flag_issue_ready=0. Issue and writeback in the same cycle → counter stays 3, flag_issue_ready=1.
- Flags 1001 (N=1, V=1): br_cond 10 GE → taken=1; 11 LT → 0; 12 GT → 1; 15 NV → 0. br_cond=14 with pending=2 → accepted immediately, taken=1.
- Branch stalled in WAIT, pulse flush → no br_resp_valid, pending=0. Next branch is accepted immediately.
- Assert rst while in RESP → br_resp_valid drops asynchronously, FSM in IDLE, cond=0000.
